wb_port_arbiter: RTL and testbench

- Sequences the single register-file write port shared by the ALU result path and the memory-load path.
- Accepts write-back requests from both sources over valid/ready handshakes and grants one per cycle.
- Registers the winner, then drives the write-back mux select, both mux data inputs, the register-file write address and the write enable.
- Sits between EX/MEM and the write-back mux. Memory loads have default priority; a starvation counter guarantees ALU progress.

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 tb/tb_wb_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates ALU and load write-backs onto the single register-file write port (optional WB_FWD_EN adds bypass hit compares)
module wb_port_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_sel,
    output logic [DW-1:0] wb_mem_data,
    output logic [DW-1:0] wb_reg_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
`ifdef WB_FWD_EN
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          fwd_rs1_hit,
    output logic          fwd_rs2_hit,
`endif
    output logic          alu_starved
);
    typedef enum logic {PRI_MEM, PRI_ALU} state_t;
    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic          alu_gnt, mem_gnt;
    logic          we_q, sel_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] mem_data_q, reg_data_q;
    // Grant: ALU wins when alone or when it holds priority; ready is forced low while in reset
    always_comb begin
        alu_gnt   = alu_valid && (!mem_valid || state_q == PRI_ALU);
        mem_gnt   = mem_valid && !alu_gnt;
        alu_ready = alu_gnt && !rst;
        mem_ready = mem_gnt && !rst;
    end
    // Priority FSM: count consecutive ALU denials and flip priority after MAX_WAIT of them
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (state_q == PRI_ALU) begin
            if (alu_valid) begin
                state_d = PRI_MEM;
                wait_d  = '0;
            end
        end else if (!alu_valid || alu_gnt) begin
            wait_d = '0;
        end else if (wait_q == 4'(MAX_WAIT - 1)) begin
            state_d = PRI_ALU;
            wait_d  = '0;
        end else if (wait_q != 4'hF) begin
            wait_d = wait_q + 4'd1;
        end
    end
    // FSM state and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI_MEM;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
    // Write-back stage: capture the winner; the unselected data register keeps its value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            sel_q      <= 1'b0;
            waddr_q    <= '0;
            mem_data_q <= '0;
            reg_data_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (alu_gnt) begin
                we_q       <= alu_rd != '0;
                sel_q      <= 1'b0;
                waddr_q    <= alu_rd;
                reg_data_q <= alu_data;
            end else if (mem_gnt) begin
                we_q       <= mem_rd != '0;
                sel_q      <= 1'b1;
                waddr_q    <= mem_rd;
                mem_data_q <= mem_rdata;
            end
        end
    end
    assign rf_we       = we_q;
    assign wb_sel      = sel_q;
    assign rf_waddr    = waddr_q;
    assign wb_mem_data = mem_data_q;
    assign wb_reg_data = reg_data_q;
    assign alu_starved = state_q == PRI_ALU;
`ifdef WB_FWD_EN
    assign fwd_rs1_hit = we_q && waddr_q == rs1_addr && rs1_addr != '0;
    assign fwd_rs2_hit = we_q && waddr_q == rs2_addr && rs2_addr != '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter (define WB_FWD_EN to exercise bypass hits)
module tb_wb_port_arbiter;
    logic        clk = 0, rst = 1;
    logic        alu_valid = 0, mem_valid = 0, alu_ready, mem_ready;
    logic [4:0]  alu_rd = 0, mem_rd = 0, rf_waddr;
    logic [31:0] alu_data = 0, mem_rdata = 0, wb_mem_data, wb_reg_data;
    logic        wb_sel, rf_we, alu_starved;
`ifdef WB_FWD_EN
    logic [4:0]  rs1_addr = 5'd9, rs2_addr = 5'd0;
    logic        fwd_rs1_hit, fwd_rs2_hit;
`endif
    int errors = 0, checks = 0;
    typedef struct {logic we; logic [4:0] a; logic sel; logic [31:0] m; logic [31:0] r;} exp_t;
    exp_t q[$];
    logic [31:0] exp_mem = 0, exp_reg = 0;

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .wb_sel(wb_sel), .wb_mem_data(wb_mem_data), .wb_reg_data(wb_reg_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr),
`ifdef WB_FWD_EN
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
`endif
        .alu_starved(alu_starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_we"}, 32'(rf_we), 0);
        chk({n, "_waddr"}, 32'(rf_waddr), 0);
        chk({n, "_sel"}, 32'(wb_sel), 0);
        chk({n, "_mem"}, wb_mem_data, 0);
        chk({n, "_reg"}, wb_reg_data, 0);
        chk({n, "_ready"}, 32'({alu_ready, mem_ready}), 0);
        chk({n, "_starved"}, 32'(alu_starved), 0);
    endtask

    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic ear, input logic emr, input logic est);
        exp_t e;
        @(negedge clk);
        rst = 0;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_rdata = md;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("alu_starved", 32'(alu_starved), 32'(est));
        if (ear) begin
            exp_reg = ad;
            e = '{ard != 0, ard, 1'b0, exp_mem, exp_reg};
            q.push_back(e);
        end else if (emr) begin
            exp_mem = md;
            e = '{mrd != 0, mrd, 1'b1, exp_mem, exp_reg};
            q.push_back(e);
        end
    endtask

    // Monitor: a handshake seen at an edge pops one expected write-back; otherwise rf_we must stay low
    initial begin
        logic f;
        exp_t e;
        forever begin
            @(posedge clk);
            f = !rst && ((alu_valid && alu_ready) || (mem_valid && mem_ready));
            #1;
            if (!rst) begin
                if (f) begin
                    if (q.size() == 0) begin
                        chk("unexpected_transfer", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rf_we", 32'(rf_we), 32'(e.we));
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
                        chk("wb_sel", 32'(wb_sel), 32'(e.sel));
                        chk("wb_mem_data", wb_mem_data, e.m);
                        chk("wb_reg_data", wb_reg_data, e.r);
                    end
                end else begin
                    chk("idle_rf_we", 32'(rf_we), 0);
                end
            end
        end
    end

    initial begin
        #1 chk_all_zero("reset");
        step(0, 0, 0, 1, 7, 32'h1234, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 32'hA, 1, 10, 32'h100, 0, 1, 0);
        step(1, 3, 32'hA, 1, 11, 32'h101, 0, 1, 0);
        step(1, 3, 32'hA, 1, 12, 32'h102, 0, 1, 0);
        step(1, 3, 32'hA, 1, 13, 32'h103, 1, 0, 1);
        step(0, 0, 0, 1, 13, 32'h103, 0, 1, 0);
        step(1, 4, 32'hB, 1, 20, 32'h200, 0, 1, 0);
        step(1, 4, 32'hB, 1, 21, 32'h201, 0, 1, 0);
        step(1, 4, 32'hB, 0, 0, 0, 1, 0, 0);
        step(1, 5, 32'hC, 1, 22, 32'h202, 0, 1, 0);
        step(1, 5, 32'hC, 1, 23, 32'h203, 0, 1, 0);
        step(1, 5, 32'hC, 1, 24, 32'h204, 0, 1, 0);
        step(1, 5, 32'hC, 1, 25, 32'h205, 1, 0, 1);
        step(0, 0, 0, 1, 25, 32'h205, 0, 1, 0);
        step(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) step(1, 5'(i), 32'(i * 17), 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; mem_valid = 0;
        #1 chk_all_zero("mid_reset");
        exp_mem = 0;
        exp_reg = 0;
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_FWD_EN
        step(1, 9, 32'h99, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        chk("fwd_rs1_hit", 32'(fwd_rs1_hit), 1);
        chk("fwd_rs2_hit", 32'(fwd_rs2_hit), 0);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
